// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI data-island datapath: period codes,
// control-bit patterns, period lengths and the island scheduler state set.
package hdmi_pkg;

    localparam logic [1:0] PERIOD_CONTROL  = 2'd0;
    localparam logic [1:0] PERIOD_PREAMBLE = 2'd1;
    localparam logic [1:0] PERIOD_GUARD    = 2'd2;
    localparam logic [1:0] PERIOD_DATA     = 2'd3;

    localparam logic [3:0] CTL_IDLE          = 4'b0000;
    localparam logic [3:0] CTL_DATA_PREAMBLE = 4'b0101;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;

    typedef enum logic [2:0] {
        ST_CTRL   = 3'd0,
        ST_PRE    = 3'd1,
        ST_LGUARD = 3'd2,
        ST_DATA   = 3'd3,
        ST_TGUARD = 3'd4
    } island_state_t;

endpackage

// File: rtl/hdmi_packet_serializer.sv
// Holds the packet currently being sent and slices out the header bit and
// the two subpacket bit-pairs belonging to one pixel of the 32-pixel packet.
// When a new packet is being loaded the incoming data is used directly, so a
// back-to-back packet shows its first pixel on the cycle right after the load.
import hdmi_pkg::*;

module hdmi_packet_serializer (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [31:0]  i_header,
    input  logic [255:0] i_sub,
    input  logic [4:0]   i_index,
    output logic         o_hdrBit,
    output logic [3:0]   o_d1,
    output logic [3:0]   o_d2
);

    logic [31:0]  r_header;
    logic [255:0] r_sub;
    logic [31:0]  w_header;
    logic [255:0] w_sub;

    // Capture the packet on every accepted transfer; reset drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_header <= '0;
            r_sub    <= '0;
        end else if (i_load) begin
            r_header <= i_header;
            r_sub    <= i_sub;
        end
    end

    assign w_header = i_load ? i_header : r_header;
    assign w_sub    = i_load ? i_sub    : r_sub;
    assign o_hdrBit = w_header[i_index];

    // Subpacket k supplies bit 2n to channel 1 and bit 2n+1 to channel 2.
    always_comb begin
        o_d1 = '0;
        o_d2 = '0;
        for (int k = 0; k < 4; k++) begin
            o_d1[k] = w_sub[{k[1:0], i_index, 1'b0}];
            o_d2[k] = w_sub[{k[1:0], i_index, 1'b1}];
        end
    end

endmodule

// File: rtl/hdmi_data_island_scheduler.sv
// Data-island sequencer: waits for enough control pixels inside blanking,
// then emits preamble, leading guard, one or more 32-pixel packets and a
// trailing guard. All outputs except pkt_ready are registered and show the
// pixel chosen at the previous clock edge.
import hdmi_pkg::*;

module hdmi_data_island_scheduler #(
    parameter int MAX_PACKETS = 18,
    parameter int MIN_CTL     = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         blank_window,
    input  logic         hsync,
    input  logic         vsync,
    input  logic         pkt_valid,
    output logic         pkt_ready,
    input  logic [31:0]  pkt_header,
    input  logic [255:0] pkt_sub,
    output logic [1:0]   period,
    output logic [3:0]   ctl,
    output logic [3:0]   d0,
    output logic [3:0]   d1,
    output logic [3:0]   d2
);

    localparam logic [4:0] LAST_PRE   = 5'(PREAMBLE_LEN - 1);
    localparam logic [4:0] LAST_GUARD = 5'(GUARD_LEN - 1);
    localparam logic [4:0] LAST_DATA  = 5'(PACKET_LEN - 1);

    island_state_t r_state;
    logic [4:0]    r_pix;
    logic [4:0]    r_pktCount;
    logic [7:0]    r_gap;
    logic [1:0]    r_period;
    logic [3:0]    r_ctl;
    logic [3:0]    r_d0;
    logic [3:0]    r_d1;
    logic [3:0]    r_d2;

    logic          w_ready;
    logic          w_xfer;
    logic          w_moreAllowed;
    logic [4:0]    w_serIdx;
    logic          w_hdrBit;
    logic [3:0]    w_subD1;
    logic [3:0]    w_subD2;
    logic [1:0]    w_sync;

    assign w_sync        = {vsync, hsync};
    assign w_moreAllowed = ({1'b0, r_pktCount} + 6'd1) < 6'(MAX_PACKETS);

    // A packet may start an island after enough control pixels, or extend
    // one at the last pixel of the current packet while the limit allows.
    assign w_ready = ((r_state == ST_CTRL) && blank_window && (r_gap >= 8'(MIN_CTL)))
                  || ((r_state == ST_DATA) && (r_pix == LAST_DATA) && w_moreAllowed);
    assign w_xfer    = w_ready && pkt_valid;
    assign pkt_ready = w_ready;

    // Pixel index that will be displayed after the coming edge.
    assign w_serIdx = ((r_state == ST_DATA) && (r_pix != LAST_DATA)) ? (r_pix + 5'd1) : 5'd0;

    hdmi_packet_serializer u_serializer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_xfer),
        .i_header (pkt_header),
        .i_sub    (pkt_sub),
        .i_index  (w_serIdx),
        .o_hdrBit (w_hdrBit),
        .o_d1     (w_subD1),
        .o_d2     (w_subD2)
    );

    // Island FSM with counters; each branch also registers the outputs for
    // the pixel it moves to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_CTRL;
            r_pix      <= '0;
            r_pktCount <= '0;
            r_gap      <= '0;
            r_period   <= PERIOD_CONTROL;
            r_ctl      <= CTL_IDLE;
            r_d0       <= '0;
            r_d1       <= '0;
            r_d2       <= '0;
        end else begin
            r_ctl <= CTL_IDLE;
            r_d0  <= {2'b00, w_sync};
            r_d1  <= '0;
            r_d2  <= '0;
            case (r_state)
                ST_CTRL: begin
                    if (w_xfer) begin
                        r_state    <= ST_PRE;
                        r_pix      <= '0;
                        r_pktCount <= '0;
                        r_gap      <= '0;
                        r_period   <= PERIOD_PREAMBLE;
                        r_ctl      <= CTL_DATA_PREAMBLE;
                    end else begin
                        if (r_gap < 8'(MIN_CTL)) begin
                            r_gap <= r_gap + 8'd1;
                        end
                        r_period <= PERIOD_CONTROL;
                    end
                end
                ST_PRE: begin
                    if (r_pix == LAST_PRE) begin
                        r_state  <= ST_LGUARD;
                        r_pix    <= '0;
                        r_period <= PERIOD_GUARD;
                        r_d0     <= {2'b11, w_sync};
                    end else begin
                        r_pix    <= r_pix + 5'd1;
                        r_period <= PERIOD_PREAMBLE;
                        r_ctl    <= CTL_DATA_PREAMBLE;
                    end
                end
                ST_LGUARD: begin
                    if (r_pix == LAST_GUARD) begin
                        r_state  <= ST_DATA;
                        r_pix    <= '0;
                        r_period <= PERIOD_DATA;
                        r_d0     <= {1'b0, w_hdrBit, w_sync};
                        r_d1     <= w_subD1;
                        r_d2     <= w_subD2;
                    end else begin
                        r_pix    <= r_pix + 5'd1;
                        r_period <= PERIOD_GUARD;
                        r_d0     <= {2'b11, w_sync};
                    end
                end
                ST_DATA: begin
                    if (r_pix == LAST_DATA) begin
                        if (w_xfer) begin
                            r_pix      <= '0;
                            r_pktCount <= r_pktCount + 5'd1;
                            r_period   <= PERIOD_DATA;
                            r_d0       <= {1'b1, w_hdrBit, w_sync};
                            r_d1       <= w_subD1;
                            r_d2       <= w_subD2;
                        end else begin
                            r_state  <= ST_TGUARD;
                            r_pix    <= '0;
                            r_period <= PERIOD_GUARD;
                            r_d0     <= {2'b11, w_sync};
                        end
                    end else begin
                        r_pix    <= r_pix + 5'd1;
                        r_period <= PERIOD_DATA;
                        r_d0     <= {1'b1, w_hdrBit, w_sync};
                        r_d1     <= w_subD1;
                        r_d2     <= w_subD2;
                    end
                end
                ST_TGUARD: begin
                    if (r_pix == LAST_GUARD) begin
                        r_state  <= ST_CTRL;
                        r_pix    <= '0;
                        r_gap    <= '0;
                        r_period <= PERIOD_CONTROL;
                    end else begin
                        r_pix    <= r_pix + 5'd1;
                        r_period <= PERIOD_GUARD;
                        r_d0     <= {2'b11, w_sync};
                    end
                end
                default: begin
                    r_state  <= ST_CTRL;
                    r_pix    <= '0;
                    r_gap    <= '0;
                    r_period <= PERIOD_CONTROL;
                end
            endcase
        end
    end

    assign period = r_period;
    assign ctl    = r_ctl;
    assign d0     = r_d0;
    assign d1     = r_d1;
    assign d2     = r_d2;

endmodule

// File: tb/tb_hdmi_data_island_scheduler.sv
// Self-checking bench for the data-island scheduler. Each stimulus cycle the
// reference model describes the island as a flat pixel timeline and pushes
// the expected outputs for that cycle into a queue; a monitor on the falling
// edge pops and compares.
module tb_hdmi_data_island_scheduler;

    localparam int MAXP = 2;
    localparam int MINC = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         blank_window = 1'b0;
    logic         hsync = 1'b0;
    logic         vsync = 1'b0;
    logic         pkt_valid = 1'b0;
    logic [31:0]  pkt_header = '0;
    logic [255:0] pkt_sub = '0;
    logic         pkt_ready;
    logic [1:0]   period;
    logic [3:0]   ctl;
    logic [3:0]   d0;
    logic [3:0]   d1;
    logic [3:0]   d2;

    hdmi_data_island_scheduler #(
        .MAX_PACKETS (MAXP),
        .MIN_CTL     (MINC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .blank_window (blank_window),
        .hsync        (hsync),
        .vsync        (vsync),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_header   (pkt_header),
        .pkt_sub      (pkt_sub),
        .period       (period),
        .ctl          (ctl),
        .d0           (d0),
        .d1           (d1),
        .d2           (d2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       care;
        logic       rdy;
        logic [1:0] period;
        logic [3:0] ctl;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
    } exp_t;

    exp_t         expQ[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           dutXfers = 0;

    // Reference model: island seen as a timeline of pixel positions.
    bit           mKnown = 0;
    bit           mActive = 0;
    int           mPos = 0;
    int           mPkts = 0;
    int           mCtl = 0;
    int           modelXfers = 0;
    logic [31:0]  mHdr[$];
    logic [255:0] mSub[$];
    exp_t         mShown = '0;

    // Outputs for the pixel the model currently points at.
    function automatic exp_t displayFor(logic hs, logic vs);
        exp_t r;
        int q, j, n;
        logic [31:0] h;
        logic [255:0] s;
        r = '0;
        r.care = 1'b1;
        r.d0 = {2'b00, vs, hs};
        if (!mActive) begin
            r.period = 2'd0;
        end else if (mPos < 8) begin
            r.period = 2'd1;
            r.ctl = 4'b0101;
        end else if (mPos < 10 || mPos >= 10 + 32 * mPkts) begin
            r.period = 2'd2;
            r.d0[3:2] = 2'b11;
        end else begin
            q = mPos - 10;
            j = q / 32;
            n = q % 32;
            h = mHdr[j];
            s = mSub[j];
            r.period = 2'd3;
            r.d0 = {(q == 0) ? 1'b0 : 1'b1, h[n], vs, hs};
            for (int k = 0; k < 4; k++) begin
                r.d1[k] = s[64 * k + 2 * n];
                r.d2[k] = s[64 * k + 2 * n + 1];
            end
        end
        return r;
    endfunction

    // Drive one cycle of inputs, record what the DUT should show during it,
    // then advance the model across the coming clock edge.
    task automatic applyStimulus(input logic rst, input logic blank, input logic valid,
                                 input logic hs, input logic vs,
                                 input logic [31:0] hdr, input logic [255:0] sub);
        exp_t e;
        bit rdy, xfer;
        @(posedge clk);
        #1;
        reset = rst;
        blank_window = blank;
        pkt_valid = valid;
        hsync = hs;
        vsync = vs;
        pkt_header = hdr;
        pkt_sub = sub;
        if (!mActive) rdy = blank && (mCtl >= MINC);
        else          rdy = (mPos == 10 + 32 * mPkts - 1) && (mPkts < MAXP);
        e = mShown;
        e.care = mKnown;
        e.rdy = rdy;
        expQ.push_back(e);
        xfer = rdy && valid && !rst;
        if (rst) begin
            mKnown = 1;
            mActive = 0;
            mCtl = 0;
            mHdr.delete();
            mSub.delete();
            mShown = '0;
            mShown.care = 1'b1;
        end else begin
            if (!mActive) begin
                if (xfer) begin
                    mActive = 1;
                    mPos = 0;
                    mPkts = 1;
                    mHdr.delete();
                    mSub.delete();
                    mHdr.push_back(hdr);
                    mSub.push_back(sub);
                    modelXfers++;
                end else if (mCtl < 1000) begin
                    mCtl++;
                end
            end else begin
                if (xfer) begin
                    mPkts++;
                    mHdr.push_back(hdr);
                    mSub.push_back(sub);
                    modelXfers++;
                end
                mPos++;
                if (mPos == 12 + 32 * mPkts) begin
                    mActive = 0;
                    mCtl = 0;
                end
            end
            mShown = displayFor(hs, vs);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.care) begin
            vectors++;
            if ({period, ctl, d0, d1, d2} !== {e.period, e.ctl, e.d0, e.d1, e.d2}) begin
                miscompares++;
                $display("[TB] FAIL outputs t=%0t got period=%0d ctl=%h d0=%h d1=%h d2=%h expected period=%0d ctl=%h d0=%h d1=%h d2=%h",
                         $time, period, ctl, d0, d1, d2, e.period, e.ctl, e.d0, e.d1, e.d2);
            end
            vectors++;
            if (pkt_ready !== e.rdy) begin
                miscompares++;
                $display("[TB] FAIL pkt_ready t=%0t got %b expected %b", $time, pkt_ready, e.rdy);
            end
        end
    endtask

    task automatic checkCount(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("[TB] FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    function automatic logic [255:0] randSub();
        logic [255:0] s;
        for (int i = 0; i < 8; i++) s[32 * i +: 32] = $urandom;
        return s;
    endfunction

    // Monitor: compare whatever the DUT shows this cycle against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (pkt_valid && pkt_ready && !reset) dutXfers++;
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    localparam logic [31:0] HDR0 = 32'h000D0284;

    initial begin
        logic [255:0] subA;
        int startX;
        subA = '0;
        subA[63:0] = 64'hAAAAAAAAAAAAAAAA;

        // Startup timing and single-packet island with fixed content.
        applyStimulus(1, 1, 1, 1, 0, HDR0, subA);
        applyStimulus(1, 1, 1, 1, 0, HDR0, subA);
        startX = dutXfers;
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 1, 0, HDR0, subA);
        @(negedge clk); #1;
        checkCount("noXferFirst4", dutXfers - startX, 0);
        applyStimulus(0, 1, 1, 1, 0, HDR0, subA);
        @(negedge clk); #1;
        checkCount("xferCycle5", dutXfers - startX, 1);
        for (int i = 0; i < 50; i++) applyStimulus(0, 1, 0, 1, 0, HDR0, subA);
        @(negedge clk); #1;
        checkCount("singleIsland", dutXfers - startX, 1);

        // Valid held: packet limit bounds the island to two back-to-back packets.
        applyStimulus(1, 1, 0, 0, 0, '0, '0);
        startX = dutXfers;
        for (int i = 0; i < 80; i++)
            applyStimulus(0, 1, 1, 1'($urandom), 1'($urandom), $urandom, randSub());
        @(negedge clk); #1;
        checkCount("maxPackets", dutXfers - startX, 2);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 1'($urandom), 1'($urandom), '0, '0);

        // Outside blanking nothing is accepted.
        startX = dutXfers;
        for (int i = 0; i < 60; i++)
            applyStimulus(0, 0, 1, 1'($urandom), 1'($urandom), $urandom, randSub());
        @(negedge clk); #1;
        checkCount("noBlankNoXfer", dutXfers - startX, 0);

        // Reset in the middle of a packet, then a fresh island.
        for (int i = 0; i < 20 && !mActive; i++)
            applyStimulus(0, 1, 1, 1, 0, $urandom, randSub());
        for (int i = 0; i < 60 && !(mActive && mPos == 20); i++)
            applyStimulus(0, 1, 0, 1, 0, '0, '0);
        checkCount("reachedData10", mPos, 20);
        applyStimulus(1, 1, 0, 1, 0, '0, '0);
        startX = dutXfers;
        for (int i = 0; i < 30; i++) applyStimulus(0, 1, 1, 1, 1, $urandom, randSub());
        for (int i = 0; i < 60; i++) applyStimulus(0, 1, 0, 1, 1, '0, '0);
        @(negedge clk); #1;
        checkCount("reissueAfterReset", dutXfers - startX, 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++)
            applyStimulus(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 9) != 0),
                          1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                          $urandom, randSub());
        applyStimulus(0, 0, 0, 0, 0, '0, '0);
        @(negedge clk); #1;
        checkCount("modelVsDutXfers", dutXfers, modelXfers);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hdmi_data_island_scheduler.md
# hdmi_data_island_scheduler

Sequences HDMI data-island periods for the TMDS datapath, producing per-pixel period codes, CTL bits and the 4-bit nibbles fed to the three channel TERC4 encoders. It accepts pre-formed InfoFrame/audio packets (header and subpackets with BCH ECC already appended) through a valid/ready handshake. It emits control → preamble → leading guard → 32-pixel packets → trailing guard during horizontal blanking. It sits between the packet builders and the per-channel TERC4 encoders and output mux.

## Interface
- MAX_PACKETS, default 18: maximum packets per island (1..18).
- MIN_CTL, default 4: control-period pixels required before a preamble may start.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- blank_window  in  1  high while a full island fits in the remaining blanking; sampled only at island start.
- hsync, vsync  in  1 each  raw syncs; carried in channel-0 bits 0/1.
- pkt_valid  in  1  packet available.
- pkt_ready  out  1  packet accepted when pkt_valid && pkt_ready (combinational).
- pkt_header  in  32  HB0..HB2 + ECC byte; bit i sent at pixel i.
- pkt_sub  in  256  subpackets 0..3, 64 bits each, subpacket k at [64k+63:64k].
- period  out  2  0=CONTROL, 1=PREAMBLE, 2=GUARD, 3=DATA (registered).
- ctl  out  4  CTL3..0 for channels 1/2 during CONTROL/PREAMBLE.
- d0, d1, d2  out  4 each  TERC4 input nibbles for channels 0/1/2.

## Operation
- States: CTRL, PRE (8 px), LGUARD (2 px), DATA (32 px per packet), TGUARD (2 px). 5-bit pixel counter, 5-bit packet counter, saturating control-gap counter (saturates at MIN_CTL).
- CTRL: ctl=0000; control-gap counter increments each cycle. pkt_ready = blank_window && gap ≥ MIN_CTL. On transfer: latch header/subpackets, clear counters, enter PRE.
- PRE: ctl=0101 (CTL0=1, CTL2=1) for 8 px, then LGUARD.
- LGUARD/TGUARD: period=GUARD; d0={1,1,vsync,hsync}; d1, d2 don't-care (downstream substitutes the fixed guard code).
- DATA at pixel n (0..31):
  - d0 = {first, header[n], vsync, hsync}, where bit3 = 0 only at pixel 0 of the first packet of the island, else 1.
  - d1[k] = sub_k[2n].
  - d2[k] = sub_k[2n+1].
- At DATA n=31:
  - pkt_ready = (pkts_sent+1 < MAX_PACKETS).
  - On transfer: latch the new packet and restart DATA at n=0 with no guard.
  - Otherwise: enter TGUARD, then CTRL with the gap counter cleared.
- pkt_ready is 0 in PRE, LGUARD, TGUARD, and DATA n≠31.
- blank_window deasserting mid-island is ignored; the island always completes.
- hsync/vsync are passed through every cycle, including CTRL (d0 low bits valid in all periods).

## Timing
- period/ctl/d0..d2 are registered: they reflect the state of the previous cycle's decision. The first PRE pixel appears on the cycle after the transfer.
- Island length = 8 + 2 + 32·P + 2 pixels for P packets.
- Reset values: state=CTRL, period=0, ctl=0000, d0=d1=d2=0, pkt_ready=0, gap counter=0. MIN_CTL clean cycles are needed after reset before the first transfer.
- Reset asserted mid-island: next cycle outputs the reset values and the held packet is dropped. The producer must re-offer the packet; it is not consumed twice.
- pkt_valid may drop without a transfer; no state change.

## Structure
- Shared package hdmi_pkg holds:
  - period codes (CONTROL/PREAMBLE/GUARD/DATA);
  - CTL_DATA_PREAMBLE = 4'b0101;
  - lengths PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32;
  - state enum.
- One natural sub-module: hdmi_packet_serializer. It holds the latched packet and emits d0[2]/d1/d2 bits for pixel index n; the scheduler owns the FSM and counters.

## Test plan
- Reset, then hold pkt_valid=1 and blank_window=1 → no transfer for the first 4 cycles. Transfer on cycle 5, then period sequence: 8×1, 2×2, 32×3, 2×2, then 0.
- Header 0x00_0D_02_84 with hsync=1, vsync=0 → DATA pixel 0 d0=4'b0001, pixel 1 d0=4'b1001. Pixel n bit2 equals header[n] for all n.
- Subpacket 0 = 0xAAAA…AA, others 0 → every DATA pixel has d1[0]=0, d2[0]=1, and d1[3:1]=d2[3:1]=0.
- MAX_PACKETS=2, pkt_valid held → exactly 2 transfers. 64 DATA pixels, no guard between packets; second packet's pixel 0 has d0[3]=1.
- blank_window=0 with pkt_valid=1 → pkt_ready=0 and period stays 0 indefinitely.
- Reset pulsed at DATA n=10 → next cycle period=0 and all outputs 0. Re-issue after MIN_CTL cycles → fresh preamble.
